mcp3008_responder: RTL

MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

---
 rtl/mcp3008_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder: decodes a start/SGL/D2..D0 command from the
// master and shifts back a null bit plus a 10-bit result taken from ch_data.
module mcp3008_responder #(
  parameter int SCLK_MIN_CLKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [79:0] ch_data,
  output logic        conv_valid,
  output logic        conv_sgl,
  output logic [2:0]  conv_ch,
  output logic        frame_abort
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_CMD        = 3'd2;
  localparam logic [2:0] S_SAMPLE     = 3'd3;
  localparam logic [2:0] S_NULL       = 3'd4;
  localparam logic [2:0] S_DATA       = 3'd5;
  localparam logic [2:0] S_TAIL       = 3'd6;

  // The synchronizer plus edge strobe needs a few clk per sclk half-period.
  if (SCLK_MIN_CLKS < 4) begin : g_param_check
    $error("SCLK_MIN_CLKS must be at least 4");
  end

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic din_s1, din_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      din_s1  <= din;
      din_s2  <= din_s1;
    end
  end

  logic sclk_rise, sclk_fall, cs_rise;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;

  logic [2:0]  state;
  logic [3:0]  cmd_sr;
  logic [1:0]  cmd_cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  result;
  logic        decode_req;

  // cmd_sr[2:0] is the IN+ channel in both modes; IN- is its pair partner.
  logic [2:0]  neg_idx;
  logic [9:0]  pos_val, neg_val, sample_val;
  logic [10:0] diff;

  always_comb begin
    neg_idx    = {cmd_sr[2:1], ~cmd_sr[0]};
    pos_val    = ch_data[int'(cmd_sr[2:0]) * 10 +: 10];
    neg_val    = ch_data[int'(neg_idx) * 10 +: 10];
    diff       = {1'b0, pos_val} - {1'b0, neg_val};
    sample_val = pos_val;
    if (!cmd_sr[3]) begin
      sample_val = diff[10] ? 10'd0 : diff[9:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_sr      <= 4'd0;
      cmd_cnt     <= 2'd0;
      bit_cnt     <= 4'd0;
      result      <= 10'd0;
      decode_req  <= 1'b0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_valid  <= 1'b0;
      conv_sgl    <= 1'b0;
      conv_ch     <= 3'd0;
      frame_abort <= 1'b0;
    end else begin
      conv_valid  <= 1'b0;
      frame_abort <= 1'b0;
      decode_req  <= 1'b0;
      if (cs_rise) begin
        state       <= S_IDLE;
        dout        <= 1'b0;
        dout_oe     <= 1'b0;
        frame_abort <= (state == S_CMD) || (state == S_SAMPLE) ||
                       (state == S_NULL) || (state == S_DATA);
      end else begin
        // ch_data is only ever read here, one clk after D0 lands in cmd_sr.
        if (decode_req) begin
          conv_valid <= 1'b1;
          conv_sgl   <= cmd_sr[3];
          conv_ch    <= cmd_sr[2:0];
          result     <= sample_val;
        end
        case (state)
          S_IDLE: begin
            if (!cs_s2) state <= S_WAIT_START;
          end
          S_WAIT_START: begin
            if (sclk_rise && din_s2) begin
              state   <= S_CMD;
              cmd_cnt <= 2'd0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= {cmd_sr[2:0], din_s2};
              cmd_cnt <= cmd_cnt + 2'd1;
              if (cmd_cnt == 2'd3) begin
                state      <= S_SAMPLE;
                decode_req <= 1'b1;
              end
            end
          end
          S_SAMPLE: begin
            if (sclk_fall) begin
              dout_oe <= 1'b1;
              dout    <= 1'b0;
              state   <= S_NULL;
            end
          end
          S_NULL: begin
            if (sclk_fall) begin
              dout    <= 1'b0;
              bit_cnt <= 4'd9;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            if (sclk_fall) begin
              dout <= result[bit_cnt];
              if (bit_cnt == 4'd0) state <= S_TAIL;
              else bit_cnt <= bit_cnt - 4'd1;
            end
          end
          S_TAIL: begin
            if (sclk_fall) dout <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
